// File: rtl/key_decoder_pkg.sv
// Shared definitions for the calculator front end: ASCII codes, op codes,
// token encodings and the byte classifier used by key_decoder.
package key_decoder_pkg;

    localparam int VAL_W = 4;
    localparam int OP_W  = 2;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_UA    = 8'h41;
    localparam logic [7:0] ASC_UF    = 8'h46;
    localparam logic [7:0] ASC_LA    = 8'h61;
    localparam logic [7:0] ASC_LF    = 8'h66;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_EQ    = 8'h3D;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_ESC   = 8'h1B;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        KIND_DIG = 2'd0,
        KIND_OP  = 2'd1,
        KIND_EQ  = 2'd2
    } tok_kind_e;

    // Operator tokens carry the op code in val[1:0].
    typedef struct packed {
        tok_kind_e        kind;
        logic [VAL_W-1:0] val;
    } tok_t;

    localparam int TOK_W = $bits(tok_t);

    typedef struct packed {
        logic is_tok;
        logic is_esc;
        tok_t tok;
    } cls_t;

    function automatic cls_t classify(input logic [7:0] ch, input logic hex_en,
                                      input logic eq_cr);
        cls_t       c;
        logic [7:0] off;
        c   = '0;
        off = '0;
        if (ch >= ASC_0 && ch <= ASC_9) begin
            off        = ch - ASC_0;
            c.is_tok   = 1'b1;
            c.tok.kind = KIND_DIG;
            c.tok.val  = off[VAL_W-1:0];
        end else if (hex_en && ch >= ASC_UA && ch <= ASC_UF) begin
            off        = ch - ASC_UA + 8'd10;
            c.is_tok   = 1'b1;
            c.tok.kind = KIND_DIG;
            c.tok.val  = off[VAL_W-1:0];
        end else if (hex_en && ch >= ASC_LA && ch <= ASC_LF) begin
            off        = ch - ASC_LA + 8'd10;
            c.is_tok   = 1'b1;
            c.tok.kind = KIND_DIG;
            c.tok.val  = off[VAL_W-1:0];
        end else begin
            case (ch)
                ASC_PLUS:  begin c.is_tok = 1'b1; c.tok.kind = KIND_OP; c.tok.val = {2'b00, OP_ADD}; end
                ASC_MINUS: begin c.is_tok = 1'b1; c.tok.kind = KIND_OP; c.tok.val = {2'b00, OP_SUB}; end
                ASC_STAR:  begin c.is_tok = 1'b1; c.tok.kind = KIND_OP; c.tok.val = {2'b00, OP_MUL}; end
                ASC_SLASH: begin c.is_tok = 1'b1; c.tok.kind = KIND_OP; c.tok.val = {2'b00, OP_DIV}; end
                ASC_EQ:    begin c.is_tok = 1'b1; c.tok.kind = KIND_EQ; end
                ASC_CR:    begin c.is_tok = eq_cr; c.tok.kind = KIND_EQ; end
                ASC_ESC:   c.is_esc = 1'b1;
                default:   c.is_tok = 1'b0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/key_decoder_if.sv
// Byte-in / token-pulse-out bundle between the UART receiver, key_decoder
// and cmd_interp_FSM.
interface key_decoder_if
    import key_decoder_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rdy;
    logic                   got_dig;
    logic                   got_op;
    logic                   got_eq;
    logic                   got_esc;
    logic [VAL_W-1:0]       key_val;
    logic [OP_W-1:0]        op_code;
    logic                   bad_char;
    logic                   overflow;
    logic [$clog2(DEPTH):0] q_level;

    modport master (
        output rx_data, rx_valid, rdy,
        input  got_dig, got_op, got_eq, got_esc, key_val, op_code,
               bad_char, overflow, q_level
    );

    modport slave (
        input  rx_data, rx_valid, rdy,
        output got_dig, got_op, got_eq, got_esc, key_val, op_code,
               bad_char, overflow, q_level
    );
endinterface

// File: rtl/key_decoder_tok_fifo.sv
// Small synchronous token FIFO with flush; rdata shows the head entry
// combinationally so the popper sees it in the same cycle.
module tok_fifo
    import key_decoder_pkg::*;
#(
    parameter  int WIDTH = TOK_W,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full queue is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/key_decoder.sv
// Classifies received ASCII bytes into calculator tokens, queues them and
// hands them to cmd_interp_FSM as spaced one-cycle pulses while rdy is high.
module key_decoder
    import key_decoder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter bit HEX_EN = 1'b0,
    parameter bit EQ_CR  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    key_decoder_if.slave bus
);
    localparam int LW = $clog2(DEPTH) + 1;

    cls_t             cls;
    logic             esc_now;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [LW-1:0]    level;
    logic [TOK_W-1:0] push_tok;
    logic [TOK_W-1:0] head_raw;
    tok_t             head;

    logic             gap;
    logic             got_dig;
    logic             got_op;
    logic             got_eq;
    logic             got_esc;
    logic             bad_char;
    logic             overflow;
    logic [VAL_W-1:0] key_val;
    logic [OP_W-1:0]  op_code;

    assign cls      = classify(bus.rx_data, HEX_EN, EQ_CR);
    assign esc_now  = bus.rx_valid && cls.is_esc;
    assign push     = bus.rx_valid && cls.is_tok;
    assign push_tok = cls.tok;
    assign head     = tok_t'(head_raw);
    // ESC pre-empts any pop so the FSM never sees a token alongside the clear.
    assign pop      = !empty && bus.rdy && !gap && !esc_now;
    assign drop     = push && full && !pop;

    tok_fifo #(
        .WIDTH (TOK_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push && !drop),
        .pop   (pop),
        .flush (esc_now),
        .wdata (push_tok),
        .rdata (head_raw),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // gap mirrors "a pulse is on the wire now", giving the FSM a cycle to drop rdy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gap      <= 1'b0;
            got_dig  <= 1'b0;
            got_op   <= 1'b0;
            got_eq   <= 1'b0;
            got_esc  <= 1'b0;
            bad_char <= 1'b0;
            overflow <= 1'b0;
            key_val  <= '0;
            op_code  <= '0;
        end else begin
            gap      <= pop || esc_now;
            got_dig  <= pop && (head.kind == KIND_DIG);
            got_op   <= pop && (head.kind == KIND_OP);
            got_eq   <= pop && (head.kind == KIND_EQ);
            got_esc  <= esc_now;
            bad_char <= bus.rx_valid && !cls.is_tok && !cls.is_esc;
            if (pop && head.kind == KIND_DIG) key_val <= head.val;
            if (pop && head.kind == KIND_OP)  op_code <= head.val[OP_W-1:0];
            if (esc_now)   overflow <= 1'b0;
            else if (drop) overflow <= 1'b1;
        end
    end

    assign bus.got_dig  = got_dig;
    assign bus.got_op   = got_op;
    assign bus.got_eq   = got_eq;
    assign bus.got_esc  = got_esc;
    assign bus.bad_char = bad_char;
    assign bus.overflow = overflow;
    assign bus.key_val  = key_val;
    assign bus.op_code  = op_code;
    assign bus.q_level  = level;
endmodule

// File: tb/tb_key_decoder.sv
// Bench for key_decoder: fixed vector table, hand sequences for queue/ESC/reset
// corners, then random bytes checked against a queue-based reference model.
module tb_key_decoder;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_decoder_if #(.DEPTH(DEPTH)) if0 ();
    key_decoder_if #(.DEPTH(DEPTH)) if1 ();

    key_decoder #(.DEPTH(DEPTH), .HEX_EN(1'b0), .EQ_CR(1'b1)) dut0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    key_decoder #(.DEPTH(DEPTH), .HEX_EN(1'b1), .EQ_CR(1'b1)) dut1 (
        .clk (clk), .rst (rst), .bus (if1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: token queue (kind*16 + value) plus the visible outputs.
    int mq[$];
    bit m_dig, m_op, m_eq, m_esc, m_bad, m_ovf;
    int m_kv, m_oc;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[28];

    function automatic logic [14:0] ex(input logic [5:0] pul, input int kv, input int oc,
                                       input int lvl);
        return {pul, 4'(kv), 2'(oc), 3'(lvl)};
    endfunction

    function automatic vec_t mkv(input logic v, input logic [7:0] d, input logic r,
                                 input logic [5:0] pul, input int kv, input int oc,
                                 input int lvl);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.exp = ex(pul, kv, oc, lvl);
        return t;
    endfunction

    function automatic logic [14:0] act0();
        return {if0.got_dig, if0.got_op, if0.got_eq, if0.got_esc, if0.bad_char,
                if0.overflow, if0.key_val, if0.op_code, if0.q_level};
    endfunction

    function automatic logic [14:0] act1();
        return {if1.got_dig, if1.got_op, if1.got_eq, if1.got_esc, if1.bad_char,
                if1.overflow, if1.key_val, if1.op_code, if1.q_level};
    endfunction

    // -2 escape, -1 illegal, otherwise kind*16 + value
    function automatic int ref_class(input logic [7:0] b, input bit hex);
        int x;
        x = int'(b);
        if (x >= 48 && x <= 57) return x - 48;
        if (hex && x >= 65 && x <= 70) return x - 55;
        if (hex && x >= 97 && x <= 102) return x - 87;
        case (x)
            43: return 16;
            45: return 17;
            42: return 18;
            47: return 19;
            61: return 32;
            13: return 32;
            27: return -2;
            default: return -1;
        endcase
    endfunction

    task automatic model_step(input logic v, input logic [7:0] d, input logic r);
        int c, t;
        bit busy;
        if (!rst) begin
            mq.delete();
            {m_dig, m_op, m_eq, m_esc, m_bad, m_ovf} = '0;
            m_kv = 0; m_oc = 0;
            return;
        end
        c    = v ? ref_class(d, 1'b0) : -3;
        busy = m_dig | m_op | m_eq | m_esc;
        {m_dig, m_op, m_eq, m_esc} = '0;
        m_bad = (c == -1);
        if (c == -2) begin
            mq.delete();
            m_ovf = 1'b0;
            m_esc = 1'b1;
        end else begin
            if (mq.size() != 0 && r && !busy) begin
                t = mq.pop_front();
                case (t / 16)
                    0: begin m_dig = 1'b1; m_kv = t % 16; end
                    1: begin m_op  = 1'b1; m_oc = t % 16; end
                    default: m_eq = 1'b1;
                endcase
            end
            if (c >= 0) begin
                if (mq.size() < DEPTH) mq.push_back(c);
                else m_ovf = 1'b1;
            end
        end
    endtask

    function automatic logic [14:0] model_exp();
        return {m_dig, m_op, m_eq, m_esc, m_bad, m_ovf, 4'(m_kv), 2'(m_oc), 3'(mq.size())};
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (dig,op,eq,esc,bad,ovf|kv|op|lvl)", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        if0.rx_valid = v; if0.rx_data = d; if0.rdy = r;
        model_step(v, d, r);
        @(negedge clk);
    endtask

    task automatic drive1(input logic v, input logic [7:0] d, input logic r);
        if1.rx_valid = v; if1.rx_data = d; if1.rdy = r;
        drive(1'b0, 8'h00, 1'b0);
        if1.rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int sel;
        if1.rx_valid = 1'b0; if1.rx_data = 8'h00; if1.rdy = 1'b0;

        tbl[0]  = mkv(1, "7",   1, 6'b000000, 0, 0, 1);
        tbl[1]  = mkv(0, 8'h00, 1, 6'b100000, 7, 0, 0);
        tbl[2]  = mkv(0, 8'h00, 1, 6'b000000, 7, 0, 0);
        tbl[3]  = mkv(1, "1",   0, 6'b000000, 7, 0, 1);
        tbl[4]  = mkv(1, "+",   0, 6'b000000, 7, 0, 2);
        tbl[5]  = mkv(1, "2",   0, 6'b000000, 7, 0, 3);
        tbl[6]  = mkv(1, "=",   0, 6'b000000, 7, 0, 4);
        tbl[7]  = mkv(0, 8'h00, 0, 6'b000000, 7, 0, 4);
        tbl[8]  = mkv(0, 8'h00, 1, 6'b100000, 1, 0, 3);
        tbl[9]  = mkv(0, 8'h00, 1, 6'b000000, 1, 0, 3);
        tbl[10] = mkv(0, 8'h00, 1, 6'b010000, 1, 0, 2);
        tbl[11] = mkv(0, 8'h00, 1, 6'b000000, 1, 0, 2);
        tbl[12] = mkv(0, 8'h00, 1, 6'b100000, 2, 0, 1);
        tbl[13] = mkv(0, 8'h00, 1, 6'b000000, 2, 0, 1);
        tbl[14] = mkv(0, 8'h00, 1, 6'b001000, 2, 0, 0);
        tbl[15] = mkv(0, 8'h00, 1, 6'b000000, 2, 0, 0);
        tbl[16] = mkv(1, "x",   1, 6'b000010, 2, 0, 0);
        tbl[17] = mkv(0, 8'h00, 1, 6'b000000, 2, 0, 0);
        tbl[18] = mkv(1, "/",   1, 6'b000000, 2, 0, 1);
        tbl[19] = mkv(0, 8'h00, 1, 6'b010000, 2, 3, 0);
        tbl[20] = mkv(0, 8'h00, 1, 6'b000000, 2, 3, 0);
        tbl[21] = mkv(1, 8'h0D, 1, 6'b000000, 2, 3, 1);
        tbl[22] = mkv(0, 8'h00, 1, 6'b001000, 2, 3, 0);
        tbl[23] = mkv(1, "A",   1, 6'b000010, 2, 3, 0);
        tbl[24] = mkv(1, "-",   1, 6'b000000, 2, 3, 1);
        tbl[25] = mkv(1, "9",   1, 6'b010000, 2, 1, 1);
        tbl[26] = mkv(0, 8'h00, 1, 6'b000000, 2, 1, 1);
        tbl[27] = mkv(0, 8'h00, 1, 6'b100000, 9, 1, 0);

        rst = 1'b0;
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 1);
        chk("reset", act0(), ex(6'b0, 0, 0, 0));
        rst = 1'b1;

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d", i), act0(), tbl[i].exp);
        end

        // ESC lands in a cycle where a pop would otherwise happen
        drive(1, "3", 0);
        drive(1, "4", 0);
        chk("esc_pre_lvl", act0(), ex(6'b0, 9, 1, 2));
        drive(1, 8'h1B, 1);
        chk("esc_in_pop", act0(), ex(6'b000100, 9, 1, 0));
        drive(0, 8'h00, 1);
        chk("esc_quiet", act0(), ex(6'b0, 9, 1, 0));

        // fill, push+pop while full, then a real drop, then ESC clears it
        drive(1, "5", 0); drive(1, "6", 0); drive(1, "7", 0); drive(1, "8", 0);
        chk("full_lvl", act0(), ex(6'b0, 9, 1, 4));
        drive(1, "9", 1);
        chk("full_push_pop", act0(), ex(6'b100000, 5, 1, 4));
        drive(1, "0", 0);
        chk("full_drop", act0(), ex(6'b000001, 5, 1, 4));
        drive(0, 8'h00, 0);
        chk("ovf_sticky", act0(), ex(6'b000001, 5, 1, 4));
        drive(1, 8'h1B, 0);
        chk("esc_clears_ovf", act0(), ex(6'b000100, 5, 1, 0));

        // reset with three tokens queued and rdy high
        drive(1, "1", 0); drive(1, "2", 0); drive(1, "3", 0);
        chk("pre_rst_lvl", act0(), ex(6'b0, 5, 1, 3));
        rst = 1'b0;
        drive(0, 8'h00, 1);
        chk("mid_rst", act0(), ex(6'b0, 0, 0, 0));
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 1);
            chk($sformatf("post_rst%0d", i), act0(), ex(6'b0, 0, 0, 0));
        end

        // hex-enabled instance
        drive1(1, "b", 1);
        chk("hex_b_lvl", act1(), ex(6'b0, 0, 0, 1));
        drive1(0, 8'h00, 1);
        chk("hex_b", act1(), ex(6'b100000, 11, 0, 0));
        drive1(0, 8'h00, 1);
        drive1(1, "F", 1);
        drive1(0, 8'h00, 1);
        chk("hex_F", act1(), ex(6'b100000, 15, 0, 0));
        drive1(1, "x", 1);
        chk("hex_x_bad", act1(), ex(6'b000010, 15, 0, 0));

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 15);
            case (sel)
                0, 1, 2, 3, 4, 5, 6, 7, 8, 9: b = 8'(8'h30 + sel);
                10: begin
                    case ($urandom_range(0, 3))
                        0: b = 8'h2B;
                        1: b = 8'h2D;
                        2: b = 8'h2A;
                        default: b = 8'h2F;
                    endcase
                end
                11: b = 8'h3D;
                12: b = 8'h0D;
                13: b = ($urandom_range(0, 3) == 0) ? 8'h1B : 8'h35;
                14: b = 8'(8'h61 + $urandom_range(0, 5));
                default: b = 8'($urandom_range(0, 255));
            endcase
            drive(($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0, b,
                  (((i / 64) % 3 == 0) ? ($urandom_range(0, 7) == 0)
                                       : ($urandom_range(0, 3) != 0)) ? 1'b1 : 1'b0);
            chk("rand", act0(), model_exp());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
